// File: rtl/indicator_pkg.sv
// Shared definitions for the indicator LED driver: FSM state encoding,
// pending-counter width and constant helpers used to size the datapath.
package indicator_pkg;

  // Blink FSM states; only ON drives the LED.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  // Width of the queued-request counter (holds up to 7).
  localparam int PENDING_W = 3;

  typedef logic [PENDING_W-1:0] pend_t;

  // Phase timer width: enough for the longer phase plus one spare bit.
  function automatic int timer_width(input int on_cycles, input int off_cycles);
    int longest;
    longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return $clog2(longest) + 1;
  endfunction

  // Saturation limit of the request queue; a disabled queue has depth zero,
  // so every trigger arriving during a blink is dropped.
  function automatic int sat_limit(input int max_pending, input bit queue_en);
    return queue_en ? max_pending : 0;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Phase timer for the indicator driver: a down-counter that is reloaded on
// every phase entry and raises tc while it sits at zero. It holds at zero
// rather than wrapping, so an idle FSM sees a stable terminal count.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);

  logic [WIDTH-1:0] count_r;

  // Reload on request, otherwise count down and stop at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/indicator_driver.sv
// Indicator LED driver: turns single-cycle trigger pulses into fixed-length
// LED blinks separated by a forced off gap. Triggers arriving during a blink
// are queued (saturating, with an overflow pulse on drops) when the macro
// INDICATOR_QUEUE_EN is defined; otherwise they are dropped and flagged.
// clear aborts everything synchronously; reset_n does so asynchronously.
module indicator_driver
  import indicator_pkg::*;
#(
  parameter int ON_CYCLES   = 10_000_000,
  parameter int OFF_CYCLES  = 10_000_000,
  parameter int MAX_PENDING = 7
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 trigger,
  input  logic                 clear,
  output logic                 led_out,
  output logic                 busy,
  output logic [PENDING_W-1:0] pending,
  output logic                 overflow
);

`ifdef INDICATOR_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  localparam int                 TIMER_W    = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TIMER_W-1:0] ON_LOAD    = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD   = TIMER_W'(OFF_CYCLES - 1);
  localparam pend_t              PEND_LIMIT = pend_t'(sat_limit(MAX_PENDING, QUEUE_EN));

  state_e             state_r;
  state_e             state_next_s;
  pend_t              pending_r;
  pend_t              pending_next_s;
  logic               overflow_r;
  logic               overflow_next_s;
  logic               led_r;
  logic               led_next_s;
  logic               busy_r;
  logic               busy_next_s;
  logic               timer_load_s;
  logic [TIMER_W-1:0] timer_value_s;
  logic               timer_tc_s;
  logic               at_limit_s;

  // The timer's terminal count marks the last cycle of the current phase.
  cycle_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (timer_load_s),
    .load_value (timer_value_s),
    .tc         (timer_tc_s)
  );

  assign at_limit_s = (pending_r == PEND_LIMIT);

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state, timer reload and pending/overflow bookkeeping.
  always_comb begin
    state_next_s    = state_r;
    pending_next_s  = pending_r;
    overflow_next_s = 1'b0;
    timer_load_s    = 1'b0;
    timer_value_s   = {TIMER_W{1'b0}};
    if (clear) begin
      state_next_s   = IDLE;
      pending_next_s = 3'd0;
      timer_load_s   = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (trigger) begin
            state_next_s  = ON;
            timer_load_s  = 1'b1;
            timer_value_s = ON_LOAD;
          end else begin
            state_next_s = IDLE;
          end
        end
        ON: begin
          if (timer_tc_s) begin
            state_next_s  = OFF;
            timer_load_s  = 1'b1;
            timer_value_s = OFF_LOAD;
          end else begin
            state_next_s = ON;
          end
          if (trigger) begin
            if (at_limit_s) begin
              overflow_next_s = 1'b1;
            end else begin
              pending_next_s = pending_r + 3'd1;
            end
          end else begin
            pending_next_s = pending_r;
          end
        end
        OFF: begin
          if (!timer_tc_s) begin
            state_next_s = OFF;
            if (trigger) begin
              if (at_limit_s) begin
                overflow_next_s = 1'b1;
              end else begin
                pending_next_s = pending_r + 3'd1;
              end
            end else begin
              pending_next_s = pending_r;
            end
          end else if (pending_r != 3'd0) begin
            // Dequeue into the next blink; a trigger in this same cycle
            // refills the slot it frees, so the count stays put.
            state_next_s  = ON;
            timer_load_s  = 1'b1;
            timer_value_s = ON_LOAD;
            if (trigger) begin
              pending_next_s = pending_r;
            end else begin
              pending_next_s = pending_r - 3'd1;
            end
          end else if (trigger && QUEUE_EN) begin
            // Empty queue: a trigger on the last gap cycle starts the next
            // blink directly instead of being counted.
            state_next_s  = ON;
            timer_load_s  = 1'b1;
            timer_value_s = ON_LOAD;
          end else begin
            state_next_s    = IDLE;
            overflow_next_s = trigger;
          end
        end
        default: begin
          state_next_s   = IDLE;
          pending_next_s = 3'd0;
          timer_load_s   = 1'b1;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state register.
  always_comb begin
    led_next_s  = (state_next_s == ON);
    busy_next_s = (state_next_s != IDLE);
  end

  // Output and pending-counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_r  <= 3'd0;
      overflow_r <= 1'b0;
      led_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      pending_r  <= pending_next_s;
      overflow_r <= overflow_next_s;
      led_r      <= led_next_s;
      busy_r     <= busy_next_s;
    end
  end

  assign led_out  = led_r;
  assign busy     = busy_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_indicator_driver.sv
// Directed bench for indicator_driver with ON_CYCLES=4, OFF_CYCLES=3,
// MAX_PENDING=3. Each table row is a scenario written as per-cycle strings:
// the trigger string gives the input for every cycle ('1' trigger, 'B'
// trigger together with clear), the other strings give the outputs expected
// in that cycle. Index 0 is the first cycle of the scenario.
module tb_indicator_driver;

`ifdef INDICATOR_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       trigger;
  logic       clear;
  logic       led_out;
  logic       busy;
  logic       overflow;
  logic [2:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string name;
    string trig;
    string led;
    string busy;
    string pend;
    string ovf;
  } vec_t;

  vec_t tbl[$];

  always #5 clock = ~clock;

  indicator_driver #(
    .ON_CYCLES   (4),
    .OFF_CYCLES  (3),
    .MAX_PENDING (3)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .trigger  (trigger),
    .clear    (clear),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  function automatic string r(input int n, input string c);
    string s;
    s = "";
    for (int k = 0; k < n; k++) s = {s, c};
    return s;
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic run_vec(input vec_t v);
    byte c;
    for (int i = 0; i < v.trig.len(); i++) begin
      c       = v.trig[i];
      trigger = (c == "1") || (c == "B");
      clear   = (c == "B");
      @(negedge clock);
      chk({v.name, "/led"},      i, {7'd0, led_out},  8'(v.led[i]  - 8'd48));
      chk({v.name, "/busy"},     i, {7'd0, busy},     8'(v.busy[i] - 8'd48));
      chk({v.name, "/pending"},  i, {5'd0, pending},  8'(v.pend[i] - 8'd48));
      chk({v.name, "/overflow"}, i, {7'd0, overflow}, 8'(v.ovf[i]  - 8'd48));
      @(posedge clock);
      #1;
    end
    trigger = 1'b0;
    clear   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    trigger = 1'b0;
    clear   = 1'b0;
    #12;
    chk("reset/led",      0, {7'd0, led_out},  8'd0);
    chk("reset/busy",     0, {7'd0, busy},     8'd0);
    chk("reset/pending",  0, {5'd0, pending},  8'd0);
    chk("reset/overflow", 0, {7'd0, overflow}, 8'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single blink: ON cycles 3..6, OFF 7..9, IDLE from 10.
    tbl.push_back('{name: "single",
                    trig: {r(2, "0"), "1", r(9, "0")},
                    led:  {r(3, "0"), r(4, "1"), r(5, "0")},
                    busy: {r(3, "0"), r(7, "1"), r(2, "0")},
                    pend: r(12, "0"),
                    ovf:  r(12, "0")});
`ifdef INDICATOR_QUEUE_EN
    // Triggers at 2, 4, 5: blinks start at 3, 10, 17; IDLE at 24.
    tbl.push_back('{name: "queue3",
                    trig: {r(2, "0"), "1", "0", r(2, "1"), r(20, "0")},
                    led:  {r(3, "0"), r(4, "1"), r(3, "0"), r(4, "1"), r(3, "0"), r(4, "1"), r(5, "0")},
                    busy: {r(3, "0"), r(21, "1"), r(2, "0")},
                    pend: {r(5, "0"), "1", r(4, "2"), r(7, "1"), r(9, "0")},
                    ovf:  r(26, "0")});
    // Trigger held 6 cycles: queue fills to 3, last two are dropped.
    tbl.push_back('{name: "saturate",
                    trig: {r(2, "0"), r(6, "1"), r(25, "0")},
                    led:  {r(3, "0"), r(4, "1"), r(3, "0"), r(4, "1"), r(3, "0"), r(4, "1"), r(3, "0"), r(4, "1"), r(5, "0")},
                    busy: {r(3, "0"), r(28, "1"), r(2, "0")},
                    pend: {r(4, "0"), "1", "2", r(4, "3"), r(7, "2"), r(7, "1"), r(9, "0")},
                    ovf:  {r(7, "0"), r(2, "1"), r(24, "0")}});
    // pending=1 and a trigger on the last OFF cycle: count stays 1.
    tbl.push_back('{name: "lastoff_p1",
                    trig: {r(2, "0"), "1", "0", "1", r(4, "0"), "1", r(16, "0")},
                    led:  {r(3, "0"), r(4, "1"), r(3, "0"), r(4, "1"), r(3, "0"), r(4, "1"), r(5, "0")},
                    busy: {r(3, "0"), r(21, "1"), r(2, "0")},
                    pend: {r(5, "0"), r(12, "1"), r(9, "0")},
                    ovf:  r(26, "0")});
    // Empty queue and a trigger on the last OFF cycle: direct restart.
    tbl.push_back('{name: "lastoff_p0",
                    trig: {r(2, "0"), "1", r(6, "0"), "1", r(9, "0")},
                    led:  {r(3, "0"), r(4, "1"), r(3, "0"), r(4, "1"), r(5, "0")},
                    busy: {r(3, "0"), r(14, "1"), r(2, "0")},
                    pend: r(19, "0"),
                    ovf:  r(19, "0")});
    // clear with trigger mid-ON at pending=2, then clear with trigger in IDLE.
    tbl.push_back('{name: "clear",
                    trig: {r(2, "0"), r(3, "1"), "B", r(2, "0"), "B", r(3, "0")},
                    led:  {r(3, "0"), r(3, "1"), r(6, "0")},
                    busy: {r(3, "0"), r(3, "1"), r(6, "0")},
                    pend: {r(4, "0"), "1", "2", r(6, "0")},
                    ovf:  r(12, "0")});
`else
    // Triggers during ON are dropped, each with an overflow pulse.
    tbl.push_back('{name: "noq_on",
                    trig: {r(2, "0"), "1", "0", r(2, "1"), r(6, "0")},
                    led:  {r(3, "0"), r(4, "1"), r(5, "0")},
                    busy: {r(3, "0"), r(7, "1"), r(2, "0")},
                    pend: r(12, "0"),
                    ovf:  {r(5, "0"), r(2, "1"), r(5, "0")}});
    // Trigger on the last OFF cycle is dropped; OFF exits to IDLE.
    tbl.push_back('{name: "noq_lastoff",
                    trig: {r(2, "0"), "1", r(6, "0"), "1", r(2, "0")},
                    led:  {r(3, "0"), r(4, "1"), r(5, "0")},
                    busy: {r(3, "0"), r(7, "1"), r(2, "0")},
                    pend: r(12, "0"),
                    ovf:  {r(10, "0"), "1", "0"}});
    // clear beats a trigger in ON: IDLE next cycle, no overflow.
    tbl.push_back('{name: "noq_clear",
                    trig: {r(2, "0"), "1", "B", r(4, "0")},
                    led:  {r(3, "0"), "1", r(4, "0")},
                    busy: {r(3, "0"), "1", r(4, "0")},
                    pend: r(8, "0"),
                    ovf:  r(8, "0")});
`endif

    foreach (tbl[t]) run_vec(tbl[t]);

    // Asynchronous reset in the middle of a blink.
    trigger = 1'b1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    trigger = 1'b0;
    chk("midrst/pre_led",      0, {7'd0, led_out},  8'd1);
    chk("midrst/pre_pending",  0, {5'd0, pending},  QUEUE_EN ? 8'd1 : 8'd0);
    chk("midrst/pre_overflow", 0, {7'd0, overflow}, QUEUE_EN ? 8'd0 : 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst/led",      0, {7'd0, led_out},  8'd0);
    chk("midrst/busy",     0, {7'd0, busy},     8'd0);
    chk("midrst/pending",  0, {5'd0, pending},  8'd0);
    chk("midrst/overflow", 0, {7'd0, overflow}, 8'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("postrst/idle_busy", 0, {7'd0, busy}, 8'd0);
    @(posedge clock);
    #1;
    trigger = 1'b1;
    @(posedge clock);
    #1;
    trigger = 1'b0;
    chk("postrst/led",     1, {7'd0, led_out}, 8'd1);
    chk("postrst/busy",    1, {7'd0, busy},    8'd1);
    chk("postrst/pending", 1, {5'd0, pending}, 8'd0);
    repeat (4) @(posedge clock);
    #1;
    chk("postrst/off_led",  5, {7'd0, led_out}, 8'd0);
    chk("postrst/off_busy", 5, {7'd0, busy},    8'd1);
    repeat (3) @(posedge clock);
    #1;
    chk("postrst/idle", 8, {7'd0, busy}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
